// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce controller: FSM state encoding and default tuning constants.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } db_state_t;

   localparam int DEFAULT_STABLE_CYCLES = 99;
   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int DEFAULT_BCNT_W        = 8;

endpackage

// File: rtl/db_stable_timer.sv
// Stability timer for the debounce FSM: counts qualified samples and flags the last one.
module db_stable_timer #(
   parameter int STABLE_CYCLES = 99
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [CW-1:0] count;

   assign done = enable && (count == CW'(STABLE_CYCLES - 1));

   // Count holds once done so it can never wrap; the FSM clears it on the next wait entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !done) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/debounce_ctrl.sv
// Single-channel debouncer: input synchroniser, 4-state stability FSM, edge strobes and
// a saturating counter of aborted transitions.
module debounce_ctrl
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int BCNT_W        = DEFAULT_BCNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_in,
   output logic              db_level,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic              busy,
   output logic [BCNT_W-1:0] bounce_cnt
);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_q;
   db_state_t              state;
   logic                   timer_clr;
   logic                   timer_en;
   logic                   timer_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign sync_q = sync_ff[SYNC_STAGES-1];

   // Timer runs only while the synchronised level agrees with the level being waited for;
   // it is cleared on wait entry and on every abort.
   always_comb begin
      timer_clr = 1'b0;
      timer_en  = 1'b0;
      unique case (state)
         S_LOW:       timer_clr = sync_q;
         S_WAIT_HIGH: begin
            timer_clr = !sync_q;
            timer_en  = sync_q;
         end
         S_HIGH:      timer_clr = !sync_q;
         S_WAIT_LOW:  begin
            timer_clr = sync_q;
            timer_en  = !sync_q;
         end
         default:     timer_clr = 1'b1;
      endcase
   end

   db_stable_timer #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clr),
      .enable (timer_en),
      .done   (timer_done)
   );

   // busy tracks the state being entered so it is registered alongside the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LOW;
         db_level   <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         busy       <= 1'b0;
         bounce_cnt <= '0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         unique case (state)
            S_LOW: begin
               if (sync_q) begin
                  state <= S_WAIT_HIGH;
                  busy  <= 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (!sync_q) begin
                  state <= S_LOW;
                  busy  <= 1'b0;
                  if (bounce_cnt != '1) bounce_cnt <= bounce_cnt + 1'b1;
               end else if (timer_done) begin
                  state      <= S_HIGH;
                  busy       <= 1'b0;
                  db_level   <= 1'b1;
                  rise_pulse <= 1'b1;
               end
            end
            S_HIGH: begin
               if (!sync_q) begin
                  state <= S_WAIT_LOW;
                  busy  <= 1'b1;
               end
            end
            S_WAIT_LOW: begin
               if (sync_q) begin
                  state <= S_HIGH;
                  busy  <= 1'b0;
                  if (bounce_cnt != '1) bounce_cnt <= bounce_cnt + 1'b1;
               end else if (timer_done) begin
                  state      <= S_LOW;
                  busy       <= 1'b0;
                  db_level   <= 1'b0;
                  fall_pulse <= 1'b1;
               end
            end
            default: begin
               state <= S_LOW;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed self-checking bench for debounce_ctrl with STABLE_CYCLES=4, SYNC_STAGES=2, BCNT_W=8.
module tb_debounce_ctrl;

   logic       clk;
   logic       rst;
   logic       btn_in;
   logic       db_level;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       busy;
   logic [7:0] bounce_cnt;

   int n_checks;
   int n_errors;

   debounce_ctrl #(
      .STABLE_CYCLES(4),
      .SYNC_STAGES  (2),
      .BCNT_W       (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .db_level   (db_level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy),
      .bounce_cnt (bounce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs, then let the given number of rising edges pass; returns 1 time unit after the last edge.
   task automatic applyStimulus(input logic btn_val, input logic rst_val, input int cycles);
      btn_in = btn_val;
      rst    = rst_val;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Per-edge check of a full accepted transition; edge k counts from the first edge sampling the new level.
   task automatic checkEdge(input int k, input logic rising);
      checkOutput($sformatf("edge%0d_rise_%0d", k, rising), 32'(rise_pulse), 32'(rising && k == 7));
      checkOutput($sformatf("edge%0d_fall_%0d", k, rising), 32'(fall_pulse), 32'(!rising && k == 7));
      checkOutput($sformatf("edge%0d_busy_%0d", k, rising), 32'(busy), 32'(k >= 3 && k <= 6));
      checkOutput($sformatf("edge%0d_level_%0d", k, rising), 32'(db_level), 32'(rising ? (k >= 7) : (k < 7)));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      btn_in   = 1'b0;
      rst      = 1'b1;

      $display("[TB] reset with btn_in held high");
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("rst_level", 32'(db_level), 32'd0);
      checkOutput("rst_rise", 32'(rise_pulse), 32'd0);
      checkOutput("rst_fall", 32'(fall_pulse), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_bounce", 32'(bounce_cnt), 32'd0);

      $display("[TB] release reset, level rises after 7 edges");
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b0, 1);
         checkEdge(k, 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("post_rise_strobe", 32'(rise_pulse), 32'd0);
      checkOutput("post_rise_level", 32'(db_level), 32'd1);

      $display("[TB] clean release from HIGH");
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b0, 1'b0, 1);
         checkEdge(k, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("post_fall_strobe", 32'(fall_pulse), 32'd0);
      checkOutput("post_fall_level", 32'(db_level), 32'd0);

      $display("[TB] bounce: high for 3 samples then low");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus((k <= 3) ? 1'b1 : 1'b0, 1'b0, 1);
         checkOutput($sformatf("bounce%0d_rise", k), 32'(rise_pulse), 32'd0);
         checkOutput($sformatf("bounce%0d_level", k), 32'(db_level), 32'd0);
         checkOutput($sformatf("bounce%0d_busy", k), 32'(busy), 32'(k >= 3 && k <= 5));
         checkOutput($sformatf("bounce%0d_cnt", k), 32'(bounce_cnt), (k >= 6) ? 32'd1 : 32'd0);
      end

      $display("[TB] clean press then release");
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b0, 1);
         checkEdge(k, 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 2);
      checkOutput("press_hold_rise", 32'(rise_pulse), 32'd0);
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b0, 1'b0, 1);
         checkEdge(k, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 2);
      checkOutput("press_bounce_unchanged", 32'(bounce_cnt), 32'd1);

      $display("[TB] 300 short glitches, bounce counter saturates");
      for (int g = 0; g < 300; g++) begin
         applyStimulus(1'b1, 1'b0, 2);
         applyStimulus(1'b0, 1'b0, 2);
      end
      applyStimulus(1'b0, 1'b0, 4);
      checkOutput("sat_bounce", 32'(bounce_cnt), 32'd255);
      checkOutput("sat_level", 32'(db_level), 32'd0);
      checkOutput("sat_busy", 32'(busy), 32'd0);

      $display("[TB] reset while waiting for high");
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1);
      end
      checkOutput("midwait_busy", 32'(busy), 32'd1);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("midwait_rst_busy", 32'(busy), 32'd0);
      checkOutput("midwait_rst_level", 32'(db_level), 32'd0);
      checkOutput("midwait_rst_rise", 32'(rise_pulse), 32'd0);
      checkOutput("midwait_rst_bounce", 32'(bounce_cnt), 32'd0);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("after_rst_bounce", 32'(bounce_cnt), 32'd0);
      checkOutput("after_rst_level", 32'(db_level), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
